// File: rtl/trap_sequencer.sv
// Commit-stage trap controller: arbitrates interrupts against the head exception,
// resolves M/S delegation, sequences a flush handshake, then strobes the trap commit.
module trap_sequencer #(
   parameter int XLEN = 64
) (
   input  logic            clk_i,
   input  logic            arst_i,
   input  logic [XLEN-1:0] mip,
   input  logic [XLEN-1:0] mie,
   input  logic [XLEN-1:0] mideleg,
   input  logic [XLEN-1:0] medeleg,
   input  logic            mstatus_mie,
   input  logic            mstatus_sie,
   input  logic [1:0]      priv,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] stvec,
   input  logic            cmt_valid,
   output logic            cmt_ready,
   input  logic            cmt_exc,
   input  logic [5:0]      cmt_cause,
   input  logic [XLEN-1:0] cmt_pc,
   input  logic [XLEN-1:0] cmt_tval,
   output logic            flush_req,
   input  logic            flush_ack,
   output logic            instr_commit_valid,
   output logic            trap_m,
   output logic            trap_s,
   output logic            trap_async,
   output logic [XLEN-1:0] trap_pc,
   output logic [XLEN-1:0] trap_value,
   output logic [XLEN-1:0] trap_cause,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_TRAP} state_t;

   state_t          r_state, w_next_state;
   logic            r_to_s, r_async;
   logic [5:0]      r_cause;
   logic [XLEN-1:0] r_epc, r_tval, r_redirect;

   logic            w_m_ok, w_s_ok;
   logic [XLEN-1:0] w_takeable;
   logic            w_int_valid;
   logic [5:0]      w_int_cause;
   logic            w_event, w_to_s;
   logic [5:0]      w_cause;
   logic [XLEN-1:0] w_tval, w_tvec, w_base, w_redirect;

   // Delegated interrupts are never taken in M-mode; non-delegated ones are masked only by mstatus.MIE in M-mode.
   assign w_m_ok     = (priv != 2'd3) | mstatus_mie;
   assign w_s_ok     = (priv == 2'd0) | ((priv == 2'd1) & mstatus_sie);
   assign w_takeable = mip & mie & ((~mideleg & {XLEN{w_m_ok}}) | (mideleg & {XLEN{w_s_ok}}));

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_int_valid = 1'b1;
      w_int_cause = 6'd0;
      if      (w_takeable[11]) w_int_cause = 6'd11;
      else if (w_takeable[3])  w_int_cause = 6'd3;
      else if (w_takeable[7])  w_int_cause = 6'd7;
      else if (w_takeable[9])  w_int_cause = 6'd9;
      else if (w_takeable[1])  w_int_cause = 6'd1;
      else if (w_takeable[5])  w_int_cause = 6'd5;
      else                     w_int_valid = 1'b0;
   end

   assign w_event    = cmt_valid & (w_int_valid | cmt_exc);
   assign w_cause    = w_int_valid ? w_int_cause : cmt_cause;
   assign w_tval     = w_int_valid ? '0 : cmt_tval;
   assign w_to_s     = w_int_valid ? mideleg[w_cause] : (medeleg[w_cause] & (priv != 2'd3));
   assign w_tvec     = w_to_s ? stvec : mtvec;
   assign w_base     = {w_tvec[XLEN-1:2], 2'b00};
   assign w_redirect = (w_int_valid && (w_tvec[1:0] == 2'd1))
                       ? w_base + (XLEN'(w_cause) << 2) : w_base;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_event)   w_next_state = ST_FLUSH;
         ST_FLUSH: if (flush_ack) w_next_state = ST_TRAP;
         ST_TRAP:                 w_next_state = ST_IDLE;
         default:                 w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state    <= ST_IDLE;
         r_to_s     <= 1'b0;
         r_async    <= 1'b0;
         r_cause    <= '0;
         r_epc      <= '0;
         r_tval     <= '0;
         r_redirect <= '0;
      end else begin
         r_state <= w_next_state;
         // Payload is captured once and frozen until the next accepted event.
         if (r_state == ST_IDLE && w_event) begin
            r_to_s     <= w_to_s;
            r_async    <= w_int_valid;
            r_cause    <= w_cause;
            r_epc      <= cmt_pc;
            r_tval     <= w_tval;
            r_redirect <= w_redirect;
         end
      end
   end

   assign cmt_ready          = (r_state == ST_IDLE);
   assign flush_req          = (r_state == ST_FLUSH);
   assign instr_commit_valid = (r_state == ST_TRAP);
   assign redirect_valid     = (r_state == ST_TRAP);
   assign trap_m             = (r_state == ST_TRAP) & ~r_to_s;
   assign trap_s             = (r_state == ST_TRAP) & r_to_s;
   assign trap_async         = (r_state == ST_TRAP) & r_async;
   assign trap_pc            = r_epc;
   assign trap_value         = r_tval;
   assign trap_cause         = {r_async, {(XLEN-7){1'b0}}, r_cause};
   assign redirect_pc        = r_redirect;

endmodule
